// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: sequential PC generation, req/ack memory port, prefetch queue toward decode.
// Latency: first request one cycle after reset release; fetched entry visible on id_* one cycle after ack.
// Backpressure: a new request is issued only while a queue slot is free for it; id_ready=0 stalls fetch once full.
module if_prefetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                PC_STEP    = 4,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_data,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_ins,
  input  logic              id_ready
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STEP_LSB = $clog2(PC_STEP);

  // Redirect targets are aligned down to the fetch granule.
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'((64'd1 << STEP_LSB) - 64'd1);
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  DEPTH_V = CNT_W'(FIFO_DEPTH);

  // IDLE: nothing outstanding. WAIT: outstanding, result kept. DRAIN: outstanding, result discarded.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_q_pc  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_q_ins [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_free;
  logic              w_issue;
  logic [CNT_W-1:0]  w_count_next;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_req    = (r_state != S_IDLE);
  assign id_valid = (r_count != '0);

  // A redirect cancels both the push of returning data and any pop in the same cycle.
  assign w_push = (r_state == S_WAIT) & im_ack & ~redirect_valid;
  assign w_pop  = id_valid & id_ready & ~redirect_valid;

  assign w_count_next = redirect_valid ? '0
                                       : r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign w_redir_pc = redirect_pc & PC_MASK;
  assign w_pc_next  = redirect_valid ? w_redir_pc
                                     : (w_push ? r_pc + STEP_V : r_pc);

  // The port is free for a new request when nothing is outstanding or the outstanding one completes now.
  // Issuing only when a slot remains after this cycle reserves room for the single in-flight request.
  assign w_free  = ~w_req | im_ack;
  assign w_issue = w_free & (w_count_next < DEPTH_V);

  assign im_req  = w_req;
  assign im_addr = r_addr;
  assign id_pc   = r_q_pc[r_rptr];
  assign id_ins  = r_q_ins[r_rptr];

  // Fetch FSM: request issue, hold until ack, and discard of a request overtaken by a redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= RESET_PC;
      r_pc    <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
      if (w_free) begin
        r_state <= w_issue ? S_WAIT : S_IDLE;
        if (w_issue) begin
          r_addr <= w_pc_next;
        end
      end else if (redirect_valid) begin
        // Request still in flight: keep im_addr stable and throw its data away when it lands.
        r_state <= S_DRAIN;
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (!rst || redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Queue storage; id_* read straight from these registers.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_q_pc[r_wptr]  <= r_addr;
      r_q_ins[r_wptr] <= im_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: memory model with programmable wait states and
// an expected-entry queue filled from the bench's own fetch-PC model.
module tb_if_prefetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_data = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_ins;
  logic        id_ready = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          drop_next = 1'b0;
  logic [31:0] model_pc = RST_PC;
  ent_t        sb[$];

  if_prefetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_data        (im_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_ins         (id_ins),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {~a[15:0], a[31:16]};
  endfunction

  task automatic model_reset();
    sb.delete();
    drop_next = 1'b0;
    wait_cnt  = 0;
    ack_delay = 0;
    model_pc  = RST_PC;
  endtask

  // One cycle from negedge to negedge: memory answers, the model records what
  // decode should see, and the entry leaving the queue is handed back.
  task automatic step(output bit popped, output bit acked, output ent_t got,
                      output bit exp_ok, output ent_t exp);
    im_ack  = 1'b0;
    im_data = '0;
    if (im_req === 1'b1) begin
      im_data = ins_of(im_addr);
      if (wait_cnt >= ack_delay) im_ack = 1'b1;
    end
    acked  = im_ack;
    popped = (id_valid === 1'b1) && id_ready && !redirect_valid;
    got.pc  = id_pc;
    got.ins = id_ins;
    exp_ok = 1'b0;
    exp    = '0;
    if (popped && sb.size() > 0) begin
      exp    = sb.pop_front();
      exp_ok = 1'b1;
    end
    if (redirect_valid) begin
      sb.delete();
      drop_next = (im_req === 1'b1) && !im_ack;
      model_pc  = redirect_pc & 32'hFFFF_FFFC;
    end else if (im_ack) begin
      if (drop_next) begin
        drop_next = 1'b0;
      end else begin
        sb.push_back({model_pc, ins_of(model_pc)});
        model_pc += 32'd4;
      end
    end
    wait_cnt = im_ack ? 0 : ((im_req === 1'b1) ? wait_cnt + 1 : 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    im_ack = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    im_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, expected 0", im_req); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", id_valid); end
    n_checks++; if (im_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h, expected %h", im_addr, RST_PC); end
    model_reset();
    rst = 1'b1;
    n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL release_req_early: got %b, expected 0", im_req); end
    @(negedge clk);
    n_checks++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b, expected 1", im_req); end
    n_checks++; if (im_addr !== RST_PC) begin n_fail++; $display("FAIL release_addr: got %h, expected %h", im_addr, RST_PC); end
  endtask

  task automatic test_stream();
    bit p, a, eo;
    ent_t got, exp;
    int npop;
    do_reset();
    id_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 16; i++) begin
      step(p, a, got, eo, exp);
      if (p) begin
        npop++;
        n_checks++;
        if (!eo || got !== exp) begin n_fail++; $display("FAIL stream_pop: got pc=%h ins=%h, expected pc=%h ins=%h present=%0d", got.pc, got.ins, exp.pc, exp.ins, eo); end
      end
    end
    n_checks++; if (npop != 15) begin n_fail++; $display("FAIL stream_rate: got %0d pops, expected 15", npop); end
  endtask

  task automatic test_fill();
    bit p, a, eo;
    ent_t got, exp;
    int nack;
    do_reset();
    id_ready = 1'b0;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      step(p, a, got, eo, exp);
      if (a) nack++;
    end
    n_checks++; if (nack != 4) begin n_fail++; $display("FAIL fill_acks: got %0d, expected 4", nack); end
    n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_stop: got %b, expected 0", im_req); end
    n_checks++; if (id_valid !== 1'b1 || id_pc !== RST_PC) begin n_fail++; $display("FAIL fill_head: got valid=%b pc=%h, expected 1 %h", id_valid, id_pc, RST_PC); end
    id_ready = 1'b1;
    step(p, a, got, eo, exp);
    n_checks++;
    if (!p || !eo || got !== exp) begin n_fail++; $display("FAIL fill_pop: got pc=%h ins=%h, expected pc=%h ins=%h popped=%0d", got.pc, got.ins, exp.pc, exp.ins, p); end
    id_ready = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      if (im_req === 1'b1) begin
        n_checks++;
        if (im_addr !== RST_PC + 32'h10) begin n_fail++; $display("FAIL refill_addr: got %h, expected %h", im_addr, RST_PC + 32'h10); end
      end
      step(p, a, got, eo, exp);
      if (a) nack++;
    end
    n_checks++; if (nack != 1) begin n_fail++; $display("FAIL refill_acks: got %0d, expected 1", nack); end
    n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL refill_req_stop: got %b, expected 0", im_req); end
    n_checks++; if (id_pc !== RST_PC + 32'h4) begin n_fail++; $display("FAIL refill_head: got %h, expected %h", id_pc, RST_PC + 32'h4); end
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(p, a, got, eo, exp);
      if (p) begin
        n_checks++;
        if (!eo || got !== exp) begin n_fail++; $display("FAIL fill_drain: got pc=%h ins=%h, expected pc=%h ins=%h present=%0d", got.pc, got.ins, exp.pc, exp.ins, eo); end
      end
    end
  endtask

  task automatic test_wait_states();
    bit p, a, eo, done, stable;
    ent_t got, exp;
    int hold;
    do_reset();
    ack_delay = 3;
    id_ready = 1'b1;
    hold = 0;
    done = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      if (im_req !== 1'b1 || im_addr !== RST_PC) stable = 1'b0;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL wait_early_valid: got %b, expected 0", id_valid); end
      step(p, a, got, eo, exp);
      if (a) done = 1'b1; else hold++;
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL wait_ack_timeout: got no ack in 10 cycles, expected one"); end
    n_checks++; if (hold != 3) begin n_fail++; $display("FAIL wait_hold: got %0d cycles, expected 3", hold); end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL wait_addr_stable: got changing req/addr, expected %h held", RST_PC); end
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== RST_PC || id_ins !== ins_of(RST_PC)) begin
      n_fail++; $display("FAIL wait_first_entry: got valid=%b pc=%h ins=%h, expected 1 %h %h", id_valid, id_pc, id_ins, RST_PC, ins_of(RST_PC));
    end
    for (int i = 0; i < 10; i++) begin
      step(p, a, got, eo, exp);
      if (p) begin
        n_checks++;
        if (!eo || got !== exp) begin n_fail++; $display("FAIL wait_pop: got pc=%h ins=%h, expected pc=%h ins=%h present=%0d", got.pc, got.ins, exp.pc, exp.ins, eo); end
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit p, a, eo, done;
    ent_t got, exp;
    do_reset();
    id_ready = 1'b0;
    repeat (2) step(p, a, got, eo, exp);
    ack_delay = 2;
    n_checks++; if (id_valid !== 1'b1 || im_req !== 1'b1) begin n_fail++; $display("FAIL rw_pre: got valid=%b req=%b, expected 1 1", id_valid, im_req); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1002;
    step(p, a, got, eo, exp);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush: got valid=%b pc=%h, expected 0", id_valid, id_pc); end
      n_checks++; if (im_req !== 1'b1 || im_addr !== RST_PC + 32'h8) begin n_fail++; $display("FAIL rw_drain_hold: got req=%b addr=%h, expected 1 %h", im_req, im_addr, RST_PC + 32'h8); end
      step(p, a, got, eo, exp);
      if (a) done = 1'b1;
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL rw_drain_timeout: got no ack, expected one"); end
    n_checks++; if (im_req !== 1'b1 || im_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL rw_next_addr: got req=%b addr=%h, expected 1 80001000", im_req, im_addr); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped: got valid=%b pc=%h, expected 0", id_valid, id_pc); end
    for (int i = 0; i < 10; i++) begin
      step(p, a, got, eo, exp);
      if (p) begin
        n_checks++;
        if (!eo || got !== exp) begin n_fail++; $display("FAIL rw_pop: got pc=%h ins=%h, expected pc=%h ins=%h present=%0d", got.pc, got.ins, exp.pc, exp.ins, eo); end
      end
    end
  endtask

  task automatic test_redirect_pop_ack();
    bit p, a, eo;
    ent_t got, exp;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(p, a, got, eo, exp);
      if (p) begin
        n_checks++;
        if (!eo || got !== exp) begin n_fail++; $display("FAIL rpa_warm_pop: got pc=%h ins=%h, expected pc=%h ins=%h present=%0d", got.pc, got.ins, exp.pc, exp.ins, eo); end
      end
    end
    n_checks++; if (id_valid !== 1'b1 || im_req !== 1'b1) begin n_fail++; $display("FAIL rpa_pre: got valid=%b req=%b, expected 1 1", id_valid, im_req); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_2000;
    step(p, a, got, eo, exp);
    redirect_valid = 1'b0;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rpa_flush: got valid=%b pc=%h, expected 0", id_valid, id_pc); end
    n_checks++; if (im_req !== 1'b1 || im_addr !== 32'h8000_2000) begin n_fail++; $display("FAIL rpa_next_addr: got req=%b addr=%h, expected 1 80002000", im_req, im_addr); end
    step(p, a, got, eo, exp);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8000_2000) begin n_fail++; $display("FAIL rpa_head: got valid=%b pc=%h, expected 1 80002000", id_valid, id_pc); end
    for (int i = 0; i < 6; i++) begin
      step(p, a, got, eo, exp);
      if (p) begin
        n_checks++;
        if (!eo || got !== exp) begin n_fail++; $display("FAIL rpa_pop: got pc=%h ins=%h, expected pc=%h ins=%h present=%0d", got.pc, got.ins, exp.pc, exp.ins, eo); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit p, a, eo;
    ent_t got, exp;
    int npop;
    do_reset();
    id_ready = 1'b0;
    repeat (3) step(p, a, got, eo, exp);
    ack_delay = 100;
    n_checks++;
    if (id_valid !== 1'b1 || im_req !== 1'b1 || im_addr !== RST_PC + 32'hC) begin
      n_fail++; $display("FAIL mid_pre: got valid=%b req=%b addr=%h, expected 1 1 %h", id_valid, im_req, im_addr, RST_PC + 32'hC);
    end
    rst = 1'b0;
    im_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b, expected 0", id_valid); end
    n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b, expected 0", im_req); end
    n_checks++; if (im_addr !== RST_PC) begin n_fail++; $display("FAIL mid_addr: got %h, expected %h", im_addr, RST_PC); end
    model_reset();
    rst = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (im_req !== 1'b1 || im_addr !== RST_PC) begin n_fail++; $display("FAIL mid_restart: got req=%b addr=%h, expected 1 %h", im_req, im_addr, RST_PC); end
    npop = 0;
    for (int i = 0; i < 10; i++) begin
      step(p, a, got, eo, exp);
      if (p) begin
        npop++;
        n_checks++;
        if (!eo || got !== exp) begin n_fail++; $display("FAIL mid_pop: got pc=%h ins=%h, expected pc=%h ins=%h present=%0d", got.pc, got.ins, exp.pc, exp.ins, eo); end
      end
    end
    n_checks++; if (npop != 9) begin n_fail++; $display("FAIL mid_rate: got %0d pops, expected 9", npop); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_wait_states();
    test_redirect_wait();
    test_redirect_pop_ack();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch stage with a prefetch queue. It generates sequential fetch addresses from a reset vector and talks to instruction memory through a req/ack handshake that tolerates wait states. Fetched {pc, instruction} pairs are buffered in a FIFO toward decode under a valid/ready handshake. It sits between instruction memory and ID, and flushes on redirects from branch or exception logic.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction width
RESET_PC, 32'h80000000, first fetch address after reset
PC_STEP, 4, sequential address increment in bytes
FIFO_DEPTH, 4, prefetch queue entries; power of 2, ≥2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
redirect_valid  in  1  jump/exception redirect request
redirect_pc  in  ADDR_W  redirect target
im_req  out  1  memory request
im_addr  out  ADDR_W  memory address; registered, stable while im_req=1
im_ack  in  1  memory returns im_data this cycle; sampled only when im_req=1
im_data  in  DATA_W  instruction word
id_valid  out  1  queue head valid (queue non-empty)
id_pc  out  ADDR_W  PC of head entry
id_ins  out  DATA_W  instruction of head entry
id_ready  in  1  decode accepts head; pop when id_valid & id_ready

Behaviour:
- Reset (rst=0 at posedge): im_req=0, im_addr=RESET_PC, id_valid=0, queue empty, fetch PC=RESET_PC, state=IDLE, discard flag cleared. Reset has priority over everything.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; result is kept.
  - DRAIN: request outstanding; result is discarded.
- Memory rules: once im_req=1, im_req and im_addr stay unchanged until the cycle im_ack=1. A request is never withdrawn.
- Zero-wait case: if im_ack=1 in the first cycle of im_req, the transfer completes.
- Completion in WAIT: push {im_addr, im_data}; fetch PC += PC_STEP (mod 2^ADDR_W; wraps silently).
- Issue rule: at each edge, compute count_next from this cycle's push and pop. Assert im_req next cycle iff count_next < FIFO_DEPTH and no redirect is pending into DRAIN. This reserves a slot for every outstanding request, so a push never meets a full queue.
- Throughput: with im_ack tied to 1 and id_ready=1, one instruction per cycle.
- Latency: first im_req=1 on the cycle after rst goes high. First id_valid=1 one cycle after the ack.
- Redirect (has priority over push and pop in the same cycle):
  - Queue is flushed; id_valid=0 next cycle.
  - Fetch PC = redirect_pc with the low log2(PC_STEP) bits forced to 0.
  - If IDLE, or WAIT with im_ack=1 this cycle: ack data is dropped and the next request uses the new PC on the following cycle.
  - If WAIT with im_ack=0: go to DRAIN. Keep the old im_addr until ack, drop that data, then issue the new PC on the next cycle.
  - Redirect in DRAIN: update the target only; stay in DRAIN.
- Simultaneous push and pop with no redirect: count unchanged; head advances.
- Queue pointers wrap modulo FIFO_DEPTH. A count register of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- id_pc and id_ins come directly from registered queue storage; there is no combinational path from im_data to id_*.

Test Plan:
- Reset, then release with im_ack=1 always and id_ready=1:
  - im_req rises 1 cycle after release.
  - id_pc sequence 0x80000000, 0x80000004, 0x80000008… on consecutive cycles.
- Fill with id_ready=0, im_ack=1, FIFO_DEPTH=4:
  - Exactly 4 entries pushed (0x80000000–0x8000000C), then im_req=0.
  - Raising id_ready for 1 cycle pops 0x80000000, and exactly one new fetch of 0x80000010 follows.
- Wait states (ack after 3 cycles):
  - im_addr holds for 3 cycles.
  - id_valid rises the cycle after ack with the correct id_ins.
- Redirect to 0x80001002 while WAIT (ack delayed 2 cycles):
  - Old ack data is never visible on id_*.
  - Next im_addr=0x80001000; queue empty in the meantime.
- Redirect in the same cycle as pop and ack:
  - Queue flushed; ack data dropped; next id_pc=redirect target.
- rst=0 asserted mid-stream with 3 entries queued and a request outstanding:
  - Next cycle: id_valid=0, im_req=0, im_addr=0x80000000.
  - After release, fetch restarts at RESET_PC.
